// File: rtl/acc_core_multi_if.sv
// Burst and result signals of acc_core_multi, bundled as one interface.
// The testbench drives through master; the core connects through slave.
interface acc_core_multi_if #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_LANES     = 4,
  parameter int DWIDTH        = IN_DATA_WIDTH * 4,
  parameter int LEN_WIDTH     = 16
);
  logic                               run_i;
  logic [LEN_WIDTH-1:0]               len_i;
  logic                               signed_i;
  logic                               valid_i;
  logic [NUM_LANES*IN_DATA_WIDTH-1:0] number_i;
  logic                               busy_o;
  logic                               valid_o;
  logic [NUM_LANES*DWIDTH-1:0]        result_o;
  logic [NUM_LANES-1:0]               ovf_o;

  modport master (
    output run_i, len_i, signed_i, valid_i, number_i,
    input  busy_o, valid_o, result_o, ovf_o
  );

  modport slave (
    input  run_i, len_i, signed_i, valid_i, number_i,
    output busy_o, valid_o, result_o, ovf_o
  );
endinterface

// File: rtl/acc_core_multi.sv
// Multi-lane burst accumulator with a sticky overflow flag for each lane.
// Define ACC_CORE_MULTI_SAT_EN to clamp lanes on overflow; otherwise they wrap.
module acc_core_multi #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_LANES     = 4,
  parameter int DWIDTH        = IN_DATA_WIDTH * 4,
  parameter int LEN_WIDTH     = 16
) (
  input  logic            clk,
  input  logic            reset,
  acc_core_multi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e                           state_q, state_d;
  logic [LEN_WIDTH-1:0]             len_q, len_d;
  logic [LEN_WIDTH-1:0]             cnt_q, cnt_d;
  logic                             signed_q, signed_d;
  logic [NUM_LANES-1:0][DWIDTH-1:0] acc_q, acc_d;
  logic [NUM_LANES-1:0]             ovf_q, ovf_d;

  logic [NUM_LANES-1:0][DWIDTH-1:0] lane_next;
  logic [NUM_LANES-1:0]             lane_ovf;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [IN_DATA_WIDTH-1:0] op;
    logic                     op_sign;
    logic                     acc_sign;
    logic [DWIDTH:0]          sum;

    assign op       = bus.number_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    assign op_sign  = signed_q & op[IN_DATA_WIDTH-1];
    assign acc_sign = signed_q & acc_q[k][DWIDTH-1];
    // The extra top bit is the carry when unsigned and a sign guard when signed.
    assign sum      = {acc_sign, acc_q[k]} + {{(DWIDTH + 1 - IN_DATA_WIDTH){op_sign}}, op};
    assign lane_ovf[k] = signed_q ? (sum[DWIDTH] != sum[DWIDTH-1]) : sum[DWIDTH];

`ifdef ACC_CORE_MULTI_SAT_EN
    logic [DWIDTH-1:0] clamp;
    assign clamp = !signed_q ? {DWIDTH{1'b1}}
                 : op_sign   ? {1'b1, {(DWIDTH-1){1'b0}}}
                 :             {1'b0, {(DWIDTH-1){1'b1}}};
    // A lane that has already clamped stays frozen until the next run_i.
    assign lane_next[k] = ovf_q[k] ? acc_q[k] : (lane_ovf[k] ? clamp : sum[DWIDTH-1:0]);
`else
    assign lane_next[k] = sum[DWIDTH-1:0];
`endif
  end

  always_comb begin
    // NOTE: every variable gets its default first, so no path can infer a latch.
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;

    if (bus.run_i) begin
      len_d    = bus.len_i;
      signed_d = bus.signed_i;
      cnt_d    = '0;
      acc_d    = '0;
      ovf_d    = '0;
      state_d  = (bus.len_i == '0) ? DONE : ACC;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        ACC: begin
          if (bus.valid_i) begin
            acc_d = lane_next;
            ovf_d = ovf_q | lane_ovf;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == len_q) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the accumulators are reset as well, since reset must zero result_o at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= '0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge values.
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy_o   = (state_q == ACC);
  assign bus.valid_o  = (state_q == DONE);
  assign bus.result_o = acc_q;
  assign bus.ovf_o    = ovf_q;

endmodule

// File: tb/tb_acc_core_multi.sv
// Self-checking bench for acc_core_multi: a 32-bit-lane and an 8-bit-lane instance
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_acc_core_multi;

  localparam int IW   = 8;
  localparam int NL   = 4;
  localparam int LW   = 16;
  localparam int DW_A = 32;
  localparam int DW_B = 8;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              run   = 1'b0;
  logic [LW-1:0]     len   = '0;
  logic              sgn   = 1'b0;
  logic              vld   = 1'b0;
  logic [NL*IW-1:0]  num   = '0;

  int n_tests    = 0;
  int n_fail     = 0;
  int valid_seen = 0;

  always #5 clk = ~clk;

  acc_core_multi_if #(.IN_DATA_WIDTH(IW), .NUM_LANES(NL), .DWIDTH(DW_A), .LEN_WIDTH(LW)) bus_a ();
  acc_core_multi_if #(.IN_DATA_WIDTH(IW), .NUM_LANES(NL), .DWIDTH(DW_B), .LEN_WIDTH(LW)) bus_b ();

  assign bus_a.run_i    = run;
  assign bus_a.len_i    = len;
  assign bus_a.signed_i = sgn;
  assign bus_a.valid_i  = vld;
  assign bus_a.number_i = num;
  assign bus_b.run_i    = run;
  assign bus_b.len_i    = len;
  assign bus_b.signed_i = sgn;
  assign bus_b.valid_i  = vld;
  assign bus_b.number_i = num;

  acc_core_multi #(.IN_DATA_WIDTH(IW), .NUM_LANES(NL), .DWIDTH(DW_A), .LEN_WIDTH(LW)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  acc_core_multi #(.IN_DATA_WIDTH(IW), .NUM_LANES(NL), .DWIDTH(DW_B), .LEN_WIDTH(LW)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Reference model: exact integer lane values kept inside the legal range of each width.
  longint m_val [2][NL];
  bit     m_ovf [2][NL];
  bit     m_busy;
  bit     m_done;
  bit     m_sgn;
  int     m_left;

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NL; k++) begin
        m_val[d][k] = 0;
        m_ovf[d][k] = 1'b0;
      end
    m_busy = 1'b0;
    m_done = 1'b0;
    m_sgn  = 1'b0;
    m_left = 0;
  endfunction

  function automatic void add_operand(int d, int k);
    int     w    = (d == 0) ? DW_A : DW_B;
    longint span = longint'(1) << w;
    longint hi   = m_sgn ? span / 2 - 1 : span - 1;
    longint lo   = m_sgn ? -(span / 2) : 0;
    longint op   = longint'(num[k*IW +: IW]);
    longint ex;
    if (m_sgn && op >= (longint'(1) << (IW - 1))) op -= (longint'(1) << IW);
    ex = m_val[d][k] + op;
`ifdef ACC_CORE_MULTI_SAT_EN
    if (m_ovf[d][k]) return;
    if (ex > hi) begin
      m_val[d][k] = hi;
      m_ovf[d][k] = 1'b1;
    end else if (ex < lo) begin
      m_val[d][k] = lo;
      m_ovf[d][k] = 1'b1;
    end else m_val[d][k] = ex;
`else
    if (ex > hi) begin
      m_val[d][k] = ex - span;
      m_ovf[d][k] = 1'b1;
    end else if (ex < lo) begin
      m_val[d][k] = ex + span;
      m_ovf[d][k] = 1'b1;
    end else m_val[d][k] = ex;
`endif
  endfunction

  function automatic void model_edge();
    if (run) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < NL; k++) begin
          m_val[d][k] = 0;
          m_ovf[d][k] = 1'b0;
        end
      m_sgn  = sgn;
      m_left = int'(len);
      m_busy = (len != 0);
      m_done = (len == 0);
    end else if (m_busy) begin
      if (vld) begin
        for (int d = 0; d < 2; d++)
          for (int k = 0; k < NL; k++) add_operand(d, k);
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else m_done = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [NL*DW_A-1:0] ea;
    logic [NL*DW_B-1:0] eb;
    logic [NL-1:0]      oa, ob;
    for (int k = 0; k < NL; k++) begin
      ea[k*DW_A +: DW_A] = DW_A'(m_val[0][k]);
      eb[k*DW_B +: DW_B] = DW_B'(m_val[1][k]);
      oa[k] = m_ovf[0][k];
      ob[k] = m_ovf[1][k];
    end
    check({where, " busy"},     bus_a.busy_o,   m_busy);
    check({where, " valid"},    bus_a.valid_o,  m_done);
    check({where, " result_a"}, bus_a.result_o, ea);
    check({where, " ovf_a"},    bus_a.ovf_o,    oa);
    check({where, " busy_b"},   bus_b.busy_o,   m_busy);
    check({where, " valid_b"},  bus_b.valid_o,  m_done);
    check({where, " result_b"}, bus_b.result_o, eb);
    check({where, " ovf_b"},    bus_b.ovf_o,    ob);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    if (bus_a.valid_o) valid_seen++;
    check_all("cycle");
  endtask

  task automatic start(input int l, input bit s);
    run = 1'b1;
    len = LW'(l);
    sgn = s;
    vld = 1'b1;
    num = $urandom;
    tick();
    run = 1'b0;
    vld = 1'b0;
  endtask

  task automatic beat(input logic [NL*IW-1:0] n);
    vld = 1'b1;
    num = n;
    tick();
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    model_reset();
    #1 reset = 1'b1;
    #1 check_all("in_reset");
    @(posedge clk);
    #3 reset = 1'b0;

    // Unsigned burst of 3 beats, run accepted on the first edge after reset.
    start(3, 1'b0);
    check("req017 busy", bus_a.busy_o, 1'b1);
    beat(32'h0403_0201);
    beat(32'h0403_0201);
    beat(32'h0403_0201);
    check("req017 valid",  bus_a.valid_o,  1'b1);
    check("req017 lanes",  bus_a.result_o, {32'd12, 32'd9, 32'd6, 32'd3});
    check("req017 ovf",    bus_a.ovf_o,    4'h0);
    idle(1);
    check("req017 pulse",  bus_a.valid_o,  1'b0);
    vld = 1'b1;
    num = 32'h1111_1111;
    idle(2);
    vld = 1'b0;
    check("idle hold",     bus_a.result_o, {32'd12, 32'd9, 32'd6, 32'd3});

    // Signed burst with idle gaps between beats.
    start(2, 1'b1);
    beat(32'h0000_00FB);
    idle(2);
    check("req018 busy gap", bus_a.busy_o, 1'b1);
    beat(32'h0000_0003);
    check("req018 lane0",   bus_a.result_o[31:0], 32'hFFFF_FFFE);
    check("req018 lane0 b", bus_b.result_o[7:0],  8'hFE);
    check("req018 valid",   bus_a.valid_o, 1'b1);
    idle(1);

    // Restart part-way through a burst.
    v0 = valid_seen;
    start(4, 1'b0);
    beat(32'h0101_0101);
    start(1, 1'b0);
    check("req019 cleared", bus_a.result_o, 128'd0);
    beat(32'h0202_0202);
    check("req019 lanes",   bus_a.result_o, {32'd2, 32'd2, 32'd2, 32'd2});
    idle(2);
    check("req019 one pulse", valid_seen - v0, 1);

    // Zero-length burst.
    start(0, 1'b0);
    check("req020 valid",  bus_a.valid_o,  1'b1);
    check("req020 result", bus_a.result_o, 128'd0);
    idle(1);
    check("req020 idle",   bus_a.valid_o | bus_a.busy_o, 1'b0);

    // Overflow on the 8-bit instance.
    start(2, 1'b0);
    beat(32'hFFFF_FFFF);
    beat(32'hFFFF_FFFF);
`ifdef ACC_CORE_MULTI_SAT_EN
    check("req021 lanes_b", bus_b.result_o, 32'hFFFF_FFFF);
`else
    check("req021 lanes_b", bus_b.result_o, 32'hFEFE_FEFE);
`endif
    check("req021 ovf_b",   bus_b.ovf_o,    4'hF);
    check("req021 ovf_a",   bus_a.ovf_o,    4'h0);
    idle(1);

    // Reset between edges in the middle of a burst.
    start(4, 1'b1);
    beat($urandom);
    #3 reset = 1'b1;
    model_reset();
    #1 check_all("reset_mid");
    check("req022 result", bus_a.result_o, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 15) == 0);
      len = LW'($urandom_range(0, 5));
      sgn = 1'($urandom_range(0, 1));
      vld = 1'($urandom_range(0, 1));
      num = $urandom;
      tick();
    end
    run = 1'b0;
    vld = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
